ccff_chain_loader: RTL and testbench

//  Configuration-chain sequencer for the logic-tile ccff chain (frac_logic, ff and output-mux memories).

---
 rtl/ccff_chain_loader.sv | 155 +++++++++++++++
 tb/tb_ccff_chain_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Bitstream loader for one tile-column ccff chain: word handshake in, serial head/shift strobe out.
// Optional loopback parity check of the loaded chain is enabled by defining CCFF_LOOPBACK_CHECK_EN.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 11
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift,
  input  logic              ccff_tail,
  output logic              config_enable,
  output logic              busy,
  output logic              done,
  output logic              chk_fail
);

  localparam int                HCNT_W   = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [HCNT_W-1:0] HFULL    = HCNT_W'(WORD_W);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] hreg_q, hreg_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              xfer;
  logic              last_shift;

`ifdef CCFF_LOOPBACK_CHECK_EN
  logic par_in_q, par_in_d;
  logic par_out_q, par_out_d;
  logic chk_fail_q, chk_fail_d;
`endif

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q   <= S_IDLE;
      hreg_q    <= '0;
      hcnt_q    <= '0;
      bit_cnt_q <= '0;
`ifdef CCFF_LOOPBACK_CHECK_EN
      par_in_q   <= 1'b0;
      par_out_q  <= 1'b0;
      chk_fail_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      hreg_q    <= hreg_d;
      hcnt_q    <= hcnt_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef CCFF_LOOPBACK_CHECK_EN
      par_in_q   <= par_in_d;
      par_out_q  <= par_out_d;
      chk_fail_q <= chk_fail_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    hreg_d     = hreg_q;
    hcnt_d     = hcnt_q;
    bit_cnt_d  = bit_cnt_q;
    word_ready = 1'b0;
    ccff_head  = 1'b0;
    ccff_shift = 1'b0;
    xfer       = 1'b0;
    last_shift = 1'b0;
`ifdef CCFF_LOOPBACK_CHECK_EN
    par_in_d   = par_in_q;
    par_out_d  = par_out_q;
    chk_fail_d = chk_fail_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          hreg_d    = '0;
          hcnt_d    = '0;
          bit_cnt_d = '0;
`ifdef CCFF_LOOPBACK_CHECK_EN
          par_in_d   = 1'b0;
          par_out_d  = 1'b0;
          chk_fail_d = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        // Refill while the last held bit is going out, unless that bit ends the chain.
        word_ready = (hcnt_q == '0) ||
                     ((hcnt_q == HCNT_W'(1)) && (bit_cnt_q < LAST_BIT));
        xfer = word_ready && word_valid;
        if (hcnt_q != '0) begin
          ccff_shift = 1'b1;
          ccff_head  = hreg_q[WORD_W-1];
          hreg_d     = hreg_q << 1;
          hcnt_d     = hcnt_q - HCNT_W'(1);
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          last_shift = (bit_cnt_q == LAST_BIT);
`ifdef CCFF_LOOPBACK_CHECK_EN
          par_in_d = par_in_q ^ hreg_q[WORD_W-1];
`endif
        end
        if (xfer) begin
          hreg_d = word_in;
          hcnt_d = HFULL;
        end
        if (last_shift) begin
          hcnt_d = '0;
`ifdef CCFF_LOOPBACK_CHECK_EN
          // bit_cnt is reused to time the recirculation pass.
          state_d   = S_CHECK;
          bit_cnt_d = '0;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef CCFF_LOOPBACK_CHECK_EN
      S_CHECK: begin
        ccff_head  = ccff_tail;
        ccff_shift = 1'b1;
        par_out_d  = par_out_q ^ ccff_tail;
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d    = S_DONE;
          chk_fail_d = par_in_q ^ par_out_d;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign config_enable = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign busy          = config_enable;
  assign done          = (state_q == S_DONE);

`ifdef CCFF_LOOPBACK_CHECK_EN
  assign chk_fail = chk_fail_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign chk_fail    = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader: random bitstreams against a bit-order model and a
// shift-register model of a 20-bit chain; honours CCFF_LOOPBACK_CHECK_EN when defined.
module tb_ccff_chain_loader;
  localparam int CL = 20;
  localparam int WW = 8;
  localparam int CW = 5;
  localparam int NW = (CL + WW - 1) / WW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WW-1:0] word_in;
  logic          word_valid;
  logic          word_ready;
  logic          ccff_head;
  logic          ccff_shift;
  logic          ccff_tail;
  logic          config_enable;
  logic          busy;
  logic          done;
  logic          chk_fail;
  logic [CL-1:0] chain = '0;
  logic          flip_q = 1'b0;
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CNT_W(CW)) dut (
    .prog_clk(clk), .pReset(rst), .start(start), .word_in(word_in),
    .word_valid(word_valid), .word_ready(word_ready), .ccff_head(ccff_head),
    .ccff_shift(ccff_shift), .ccff_tail(ccff_tail), .config_enable(config_enable),
    .busy(busy), .done(done), .chk_fail(chk_fail)
  );

  // Chain model: advances on each strobed edge; flip_q corrupts one bit leaving the tail.
  always @(posedge clk) if (ccff_shift) chain <= {chain[CL-2:0], ccff_head};
  assign ccff_tail = chain[CL-1] ^ flip_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_load(input string tag, input bit fixed, input int stall_len,
                          input int rst_at, input bit busy_start, input bit flip);
    logic [WW-1:0] words [NW];
    logic          exp_bits [CL];
    logic [CL-1:0] exp_chain;
    int            n = 0, wi = 0, idle = 0, dones = 0, cyc = 0, exp_idle, exp_n;
    bit            finished = 0, flipped = 0;
    for (int i = 0; i < NW; i++) begin
      words[i] = WW'($urandom);
      if (fixed) begin
        case (i)
          0:       words[i] = 8'hA5;
          1:       words[i] = 8'h3C;
          default: words[i] = 8'hF0;
        endcase
      end
    end
    for (int b = 0; b < CL; b++) begin
      exp_bits[b]         = words[b / WW][WW - 1 - (b % WW)];
      exp_chain[CL-1-b]   = exp_bits[b];
    end
    exp_idle = 1 + ((stall_len > WW - 1) ? stall_len - (WW - 1) : 0);
`ifdef CCFF_LOOPBACK_CHECK_EN
    exp_n = 2 * CL;
`else
    exp_n = CL;
`endif
    @(negedge clk); start = 1'b1; word_valid = 1'b0;
    @(negedge clk); start = 1'b0;
    while (!finished && cyc < 200) begin
      if (rst_at >= 0 && n == rst_at) begin
        rst = 1'b1;
        #1;
        check({tag, "/rst_outputs"},
              32'({word_ready, ccff_head, ccff_shift, config_enable, busy, done, chk_fail}), 32'd0);
        @(negedge clk); rst = 1'b0; word_valid = 1'b0;
        return;
      end
      word_valid = !(stall_len > 0 && cyc >= 1 && cyc <= stall_len);
      word_in    = (wi < NW) ? words[wi] : WW'($urandom);
      start      = busy_start && (cyc == 10);
      flip_q     = flip && (n == CL) && !flipped;
      if (flip_q) flipped = 1;
      #1;
      if (done) begin
        finished = 1;
        dones++;
        check({tag, "/done_cfg_busy"}, 32'({config_enable, busy}), 32'd0);
        check({tag, "/chk_fail"}, 32'(chk_fail), 32'(flip));
      end else begin
        check({tag, "/cfg_busy"}, 32'({config_enable, busy}), 32'd3);
        if (ccff_shift) begin
          if (n < CL) check($sformatf("%s/head%0d", tag, n), 32'(ccff_head), 32'(exp_bits[n]));
`ifdef CCFF_LOOPBACK_CHECK_EN
          else begin
            check({tag, "/loop_head"}, 32'(ccff_head), 32'(ccff_tail));
            check({tag, "/loop_ready"}, 32'(word_ready), 32'd0);
          end
`endif
          n++;
        end else begin
          idle++;
        end
        if (word_valid && word_ready) wi++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; word_valid = 1'b0; flip_q = 1'b0;
    check({tag, "/finished"}, 32'(finished), 32'd1);
    check({tag, "/shifts"}, 32'(n), 32'(exp_n));
    check({tag, "/transfers"}, 32'(wi), 32'(NW));
    check({tag, "/idle_cycles"}, 32'(idle), 32'(exp_idle));
    if (!flip) check({tag, "/chain"}, 32'(chain), 32'(exp_chain));
    for (int k = 0; k < 3; k++) begin
      #1;
      check({tag, "/after"}, 32'({done, busy, config_enable, word_ready, ccff_shift}), 32'd0);
      @(negedge clk);
    end
    check({tag, "/single_done"}, 32'(dones), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; word_valid = 1'b0; word_in = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          32'({word_ready, ccff_head, ccff_shift, config_enable, busy, done, chk_fail}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_load("fixed",      1, 0,  -1, 0, 0);
    run_load("random",     0, 0,  -1, 0, 0);
    run_load("stall",      0, 12, -1, 0, 0);
    run_load("midreset",   0, 0,  7,  0, 0);
    run_load("reload",     0, 0,  -1, 0, 0);
    run_load("busy_start", 0, 0,  -1, 1, 0);
`ifdef CCFF_LOOPBACK_CHECK_EN
    run_load("flip",       0, 0,  -1, 0, 1);
    run_load("clean",      0, 0,  -1, 0, 0);
`endif
    for (int r = 0; r < 4; r++) run_load($sformatf("rand%0d", r), 0, $urandom_range(0, 14), -1, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
